// File: rtl/data_memory_responder.sv
// Data-memory responder: word-organised RAM with byte/word loads and stores and a fixed-latency, in-order response pipe.
// Optional feature: define DMEM_STORE_ACK_EN to make stores produce an acknowledgement response.
module data_memory_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        mem_LS,
  input  logic        mem_BMS,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_store_value,
  output logic        mem_valid_out,
  output logic        mem_LS_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_load_value_out
);

  localparam int AW     = $clog2(DEPTH_WORDS);
  localparam int STAGES = LATENCY + 1;

  logic [31:0]   ram [DEPTH_WORDS];
  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [31:0]   load_value;
  logic          resp_en;
  logic          unused_addr_bits;

  assign word_idx         = mem_address[AW+1:2];
  assign lane             = mem_address[1:0];
  assign unused_addr_bits = ^mem_address[31:AW+2];
  assign rd_word          = ram[word_idx];
  assign rd_byte          = rd_word[{lane, 3'b000} +: 8];
  assign load_value       = mem_BMS ? {{24{rd_byte[7]}}, rd_byte} : rd_word;

`ifdef DMEM_STORE_ACK_EN
  assign resp_en = mem_valid;
`else
  assign resp_en = mem_valid & mem_LS;
`endif

  // RAM is never reset; stores already committed survive a pipeline reset.
  always_ff @(posedge clk) begin
    if (rst_n && mem_valid && !mem_LS) begin
      if (mem_BMS)
        ram[word_idx][{lane, 3'b000} +: 8] <= mem_store_value[7:0];
      else
        ram[word_idx] <= mem_store_value;
    end
  end

  logic        pipe_valid [STAGES];
  logic        pipe_ls    [STAGES];
  logic [31:0] pipe_addr  [STAGES];
  logic [31:0] pipe_data  [STAGES];

  // Stage 0 captures at the accepting edge; non-responding requests enter as all-zero bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_ls[i]    <= 1'b0;
        pipe_addr[i]  <= '0;
        pipe_data[i]  <= '0;
      end
    end else begin
      pipe_valid[0] <= resp_en;
      pipe_ls[0]    <= resp_en & mem_LS;
      pipe_addr[0]  <= resp_en ? mem_address : '0;
      pipe_data[0]  <= (resp_en && mem_LS) ? load_value : '0;
      for (int i = 1; i < STAGES; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_ls[i]    <= pipe_ls[i-1];
        pipe_addr[i]  <= pipe_addr[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  assign mem_valid_out      = pipe_valid[STAGES-1];
  assign mem_LS_out         = pipe_ls[STAGES-1];
  assign mem_addr_out       = pipe_addr[STAGES-1];
  assign mem_load_value_out = pipe_data[STAGES-1];

endmodule
